// File: rtl/control_ram.sv
// control_ram: single-port byte-wide control RAM with out-of-range flagging.
// Define CONTROL_RAM_ZERO_INIT_EN to zero-clear the array after reset release.
module control_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  addrError,
  output logic                  ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic                  r_ready;

  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_user_we;
  logic                  w_sweep_we;
  logic [DEPTH_LOG2-1:0] w_sweep_idx;

  assign w_in_range = (addr >> DEPTH_LOG2) == '0;
  assign w_idx      = addr[DEPTH_LOG2-1:0];
  assign w_user_we  = reset & r_ready & writeEnable & w_in_range;

`ifdef CONTROL_RAM_ZERO_INIT_EN
  logic [DEPTH_LOG2:0] r_ptr;

  // MSB of the pointer marks the sweep as finished
  assign w_sweep_we  = reset & ~r_ready & ~r_ptr[DEPTH_LOG2];
  assign w_sweep_idx = r_ptr[DEPTH_LOG2-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else if (!r_ready) begin
      if (r_ptr[DEPTH_LOG2]) r_ready <= 1'b1;
      else                   r_ptr   <= r_ptr + 1'b1;
    end
  end
`else
  assign w_sweep_we  = 1'b0;
  assign w_sweep_idx = '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ready <= 1'b0;
    else        r_ready <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (w_sweep_we)     r_mem[w_sweep_idx] <= '0;
    else if (w_user_we) r_mem[w_idx]       <= dataIn;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (r_ready) begin
      r_err <= ~w_in_range;
      if (!w_in_range)      r_data <= '0;
      else if (writeEnable) r_data <= dataIn;
      else                  r_data <= r_mem[w_idx];
    end else begin
      r_data <= '0;
      r_err  <= 1'b0;
    end
  end

  assign dataOut   = r_data;
  assign addrError = r_err;
  assign ready     = r_ready;

endmodule

// File: tb/tb_control_ram.sv
// tb_control_ram: scoreboard bench for control_ram.
// Builds with or without CONTROL_RAM_ZERO_INIT_EN.
`timescale 1ns/1ps
module tb_control_ram;

  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int DL    = 8;
  localparam int DEPTH = 256;
`ifdef CONTROL_RAM_ZERO_INIT_EN
  localparam bit ZI        = 1'b1;
  localparam int READY_LAT = DEPTH + 1;
`else
  localparam bit ZI        = 1'b0;
  localparam int READY_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          err;
  logic          rdy;

  control_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .writeEnable(we),
    .addr(addr),
    .dataIn(din),
    .dataOut(dout),
    .addrError(err),
    .ready(rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    bit            chk_data;
    int            id;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model[int];
  int            checks = 0;
  int            passed = 0;
  int            seq = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every edge that carries an issued access produces one output
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        #1;
        check($sformatf("acc%0d err", e.id), {31'd0, err}, {31'd0, e.err});
        if (e.chk_data)
          check($sformatf("acc%0d data", e.id), {24'd0, dout}, {24'd0, e.data});
      end
    end
  end

  function automatic void model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endfunction

  task automatic access(bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    exp_t e;
    int   idx;
    @(negedge clk);
    we   = w;
    addr = a;
    din  = d;
    seq++;
    e.id  = seq;
    e.err = (a >> DL) != 0;
    idx   = int'(a[DL-1:0]);
    if (e.err) begin
      e.data     = '0;
      e.chk_data = 1'b1;
    end else if (w) begin
      e.data     = d;
      e.chk_data = 1'b1;
      model[idx] = d;
    end else if (model.exists(idx)) begin
      e.data     = model[idx];
      e.chk_data = 1'b1;
    end else begin
      e.data     = '0;
      e.chk_data = 1'b0;
    end
    q.push_back(e);
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  // Releases reset while a write to 0x02 is held, counts edges to ready
  task automatic release_and_wait();
    int n;
    bit hold_bad;
    n        = 0;
    hold_bad = 1'b0;
    @(negedge clk);
    we    = 1'b1;
    addr  = 32'h2;
    din   = 8'h77;
    reset = 1'b1;
    while (!rdy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (!rdy && (dout !== '0 || err !== 1'b0)) hold_bad = 1'b1;
    end
    we = 1'b0;
    check("ready latency", n, READY_LAT);
    check("outputs held 0 while not ready", {31'd0, hold_bad}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async rst dout", {24'd0, dout}, 32'd0);
    check("async rst err", {31'd0, err}, 32'd0);
    check("async rst ready", {31'd0, rdy}, 32'd0);
    repeat (3) @(negedge clk);
    if (ZI) model_zero();
    release_and_wait();
  endtask

  initial begin
    logic [AW-1:0] a;
    int            sel;
    int            n;

    #1;
    check("reset dout", {24'd0, dout}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset ready", {31'd0, rdy}, 32'd0);
    repeat (2) @(negedge clk);
    if (ZI) model_zero();
    release_and_wait();

    access(1'b0, 32'h0000_0000, 8'h00);
    access(1'b0, 32'h0000_00FF, 8'h00);
    access(1'b1, 32'h0000_0000, 8'h5A);
    access(1'b0, 32'h0000_0000, 8'h00);
    access(1'b1, 32'h0000_0100, 8'h3C);
    access(1'b0, 32'h0000_0100, 8'h00);
    access(1'b0, 32'h0000_0000, 8'h00);
    access(1'b1, 32'h0000_0005, 8'h11);
    access(1'b1, 32'h0000_0006, 8'h22);
    access(1'b0, 32'h0000_0005, 8'h00);
    access(1'b0, 32'h0000_0006, 8'h00);
    access(1'b0, 32'h0000_0002, 8'h00);
    access(1'b0, 32'h8000_0000, 8'h00);
    access(1'b1, 32'h0000_0010, 8'hA5);
    access(1'b0, 32'h0000_0010, 8'h00);

    do_reset();
    access(1'b0, 32'h0000_0010, 8'h00);
    access(1'b0, 32'h0000_0000, 8'h00);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        a = $urandom;
        if ((a >> DL) == 0) a = a | 32'h0000_0100;
      end else if (sel < 6) begin
        a = 32'($urandom_range(0, 15));
      end else begin
        a = 32'($urandom_range(0, DEPTH - 1));
      end
      access(1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #3;
    check("scoreboard drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/control_ram.md
Name: control_ram

Overview:
- Single-port synchronous control/configuration RAM with a wide logical address bus and a small physical array.
- Used by control logic to store and read back byte-wide settings.
- Out-of-range accesses are flagged.
- Optional post-reset zero-clear sweep.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 32, logical address bus width.
- DEPTH_LOG2, 8, log2 of physical word count (DEPTH = 2**DEPTH_LOG2 = 256). Must satisfy DEPTH_LOG2 <= ADDR_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- writeEnable  input  1  write strobe, sampled at rising clk.
- addr  input  ADDR_WIDTH  word address.
- dataIn  input  DATA_WIDTH  write data.
- dataOut  output  DATA_WIDTH  registered read data.
- addrError  output  1  registered out-of-range flag for the access sampled last cycle.
- ready  output  1  high when the RAM accepts accesses.

Behaviour:
- Reset (reset=0, asynchronous):
  - dataOut=0, addrError=0, ready=0.
  - Clear-sweep pointer reset to 0.
  - Array contents are not reset asynchronously.
- In range means addr[ADDR_WIDTH-1:DEPTH_LOG2] == 0; the index is addr[DEPTH_LOG2-1:0].
- Write, when ready=1 and writeEnable=1 at rising clk:
  - In range: mem[index] <= dataIn.
  - Out of range: no array change.
- Read, every rising clk with ready=1, whatever writeEnable is:
  - dataOut <= mem[index] if in range, else 0.
  - Latency: 1 cycle. Data for the address presented in cycle N is visible after edge N.
- Read-during-write to the same in-range address is write-first: dataOut shows the new dataIn.
- addrError <= 1 on any edge with ready=1 whose sampled addr is out of range, else 0.
  - Write and read accesses are treated alike.
  - Valid for exactly the cycle paired with the corresponding dataOut.
- While ready=0:
  - writeEnable is ignored.
  - dataOut and addrError are held at 0.
- Ready sequencing after reset release: governed by the optional feature. ready, once 1, stays 1 until the next reset assertion.
- Reset asserted mid-sweep or mid-access:
  - Outputs clear immediately.
  - The sweep restarts from index 0 after release.
  - Any array write in flight on that edge is discarded.
- Address wrap: none. Indices outside DEPTH are only handled through the addrError path.
- No X propagation: reads of never-written words return 0 when the sweep is enabled. Without the sweep they return unspecified array content.

Optional Feature:
- Macro: CONTROL_RAM_ZERO_INIT_EN
- Defined:
  - After reset release, the block writes 0 to indices 0..DEPTH-1, one per clk.
  - ready rises on the edge after the last index is written, i.e. DEPTH cycles after the first edge following release (256 for the defaults).
  - User writes are ignored during the sweep.
- Undefined:
  - No sweep; ready rises on the first rising clk after reset release.
  - Array contents are undefined until written.

Test Plan:
- Reset release, default params, macro defined: ready=0 for 256 cycles, then 1. Reading addr 0x00000000 then 0x000000FF gives dataOut=0x00 for both, addrError=0.
- When ready: write addr=0x00000000, dataIn=0x5A, writeEnable=1; then writeEnable=0, same addr. The next dataOut = 0x5A on both cycles (write-first on the write cycle).
- Out-of-range access: write 0x3C to addr=0x00000100, then read 0x00000100 and 0x00000000.
  - dataOut=0 and addrError=1 for the 0x100 accesses.
  - addr 0 still reads its prior value (0x5A), addrError=0.
- Back-to-back writes 0x11 to 0x05, 0x22 to 0x06, then reads of 0x05 and 0x06: dataOut 0x11 then 0x22, one-cycle latency.
- Reset mid-operation: write 0xA5 to 0x10, pulse reset low for 3 cycles. dataOut and ready drop to 0 asynchronously. With the macro, 0x10 reads 0x00 after ready. Without the macro, ready=1 one cycle after release.
- writeEnable=1 with addr=0x02 and dataIn=0x77 while ready=0: ignored. After ready, 0x02 reads 0x00 (macro defined).
